// File: rtl/seq_ripple_subtractor.sv
// seq_ripple_subtractor: multi-cycle ripple-borrow subtractor, diff = a - b - bin.
// One CHUNK-bit slice is subtracted per clock; the borrow between slices is
// carried in a register so the combinational path is only CHUNK bits long.
// Optional build macro: SEQ_SUB_SATURATE_EN -- clamp diff to 0 when the final
// borrow-out is 1 (bout still reports the underflow).

// Single-bit full subtractor cell.
module seq_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & (y ^ bi)) | (y & bi);
endmodule

// CHUNK-bit ripple-borrow slice built from an array of bit cells.
module seq_sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bi,
  output logic [CHUNK-1:0] d,
  output logic             bo
);
  logic [CHUNK:0] br;

  assign br[0] = bi;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    seq_sub_bit u_bit (
      .x  (x[i]),
      .y  (y[i]),
      .bi (br[i]),
      .d  (d[i]),
      .bo (br[i+1])
    );
  end

  assign bo = br[CHUNK];
endmodule

module seq_ripple_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               br_q, br_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;

  logic [IDX_W-1:0]   base;
  logic [CHUNK-1:0]   chunk_d;
  logic               chunk_bo;
  logic               last_chunk;

  // Bit offset of the slice being worked on this cycle.
  assign base       = IDX_W'(cnt_q * CHUNK);
  assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

  seq_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (a_q[base +: CHUNK]),
    .y  (b_q[base +: CHUNK]),
    .bi (br_q),
    .d  (chunk_d),
    .bo (chunk_bo)
  );

  // State and datapath registers; reset clears everything so a partial result is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  // Next-state: accept in IDLE, one slice per cycle in RUN, hold result in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[base +: CHUNK] = chunk_d;
        br_d                  = chunk_bo;
        if (last_chunk) begin
          bout_d  = chunk_bo;
          state_d = DONE;
`ifdef SEQ_SUB_SATURATE_EN
          // Underflow clamps to zero; bout still flags it.
          if (chunk_bo) diff_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags decode straight from state so reset drops them immediately.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_seq_ripple_subtractor.sv
// Self-checking bench for seq_ripple_subtractor: main instance WIDTH=16/CHUNK=4,
// second instance WIDTH=8/CHUNK=8 for the single-slice case.
module tb_seq_ripple_subtractor;
  localparam int W  = 16;
  localparam int C  = 4;
  localparam int N  = W / C;
  localparam int W2 = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          in_valid, in_ready, bin, out_valid, out_ready, bout;
  logic [W-1:0]  a, b, diff;

  logic          in_valid2, in_ready2, bin2, out_valid2, out_ready2, bout2;
  logic [W2-1:0] a2, b2, diff2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_ripple_subtractor #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
  );

  seq_ripple_subtractor #(.WIDTH(W2), .CHUNK(W2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .bin(bin2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .diff(diff2), .bout(bout2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer subtraction; negative result means borrow-out.
  function automatic logic [32:0] ref_sub(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic bi);
    longint s;
    logic [31:0] d;
    logic bo;
    s  = longint'(x) - longint'(y) - longint'(bi);
    bo = (s < 0);
    d  = 32'(s) & ((32'd1 << w) - 32'd1);
`ifdef SEQ_SUB_SATURATE_EN
    if (bo) d = '0;
`endif
    return {bo, d};
  endfunction

  // One transaction on the 16-bit instance; starts and ends on a falling edge.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                       input int stall, input bit pulse);
    logic [32:0] e;
    int g, lat;
    e = ref_sub(W, 32'(x), 32'(y), bi);
    g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    chk("idle_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = x; b = y; bin = bi;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        // Held through a RUN edge with junk operands: must be ignored.
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        bin       = 1'($urandom);
        out_ready = 1'($urandom);
      end
    end while (!out_valid && lat < 40);
    chk("latency", 32'(lat), 32'(N));
    chk("diff", 32'(diff), e[31:0]);
    chk("bout", 32'(bout), 32'(e[32]));
    chk("done_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      in_valid = pulse ? 1'($urandom) : 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_diff", 32'(diff), e[31:0]);
      chk("stall_bout", 32'(bout), 32'(e[32]));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_ready", 32'(in_ready), 32'd1);
  endtask

  // One transaction on the single-slice instance.
  task automatic do_op2(input logic [W2-1:0] x, input logic [W2-1:0] y, input logic bi);
    logic [32:0] e;
    int lat;
    e = ref_sub(W2, 32'(x), 32'(y), bi);
    chk("w8_idle_ready", 32'(in_ready2), 32'd1);
    in_valid2 = 1'b1; a2 = x; b2 = y; bin2 = bi;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid2 = 1'b0;
      a2 = W2'($urandom); b2 = W2'($urandom);
    end while (!out_valid2 && lat < 20);
    chk("w8_latency", 32'(lat), 32'd1);
    chk("w8_diff", 32'(diff2), e[31:0]);
    chk("w8_bout", 32'(bout2), 32'(e[32]));
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    chk("w8_release", 32'(out_valid2), 32'd0);
  endtask

  initial begin
    in_valid = 0; a = '0; b = '0; bin = 0; out_ready = 0;
    in_valid2 = 0; a2 = '0; b2 = '0; bin2 = 0; out_ready2 = 0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h1234, 16'h0034, 1'b0, 0, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b0, 1, 1'b0);
    do_op(16'h8000, 16'h7FFF, 1'b1, 0, 1'b0);
    do_op(16'hABCD, 16'h1111, 1'b1, 5, 1'b1);
    do_op(16'h0000, 16'hFFFF, 1'b1, 0, 1'b0);

    // Reset in the middle of RUN: outputs drop at once and nothing is presented later.
    do_op(16'h0001, 16'h0002, 1'b0, 0, 1'b0);
    in_valid = 1'b1; a = 16'h5A5A; b = 16'h0F0F; bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_ready", 32'(in_ready), 32'd1);
    chk("midrun_rst_diff", 32'(diff), 32'd0);
    chk("midrun_rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    do_op(16'h00FF, 16'h000F, 1'b0, 0, 1'b0);

    // Single-slice instance.
    do_op2(8'h05, 8'h07, 1'b0);
    do_op2(8'hFF, 8'h01, 1'b1);
    for (int i = 0; i < 6; i++) do_op2(W2'($urandom), W2'($urandom), 1'($urandom));

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 40; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
